// File: rtl/serial_master_port.sv
// serial_master_port: serial bus master that sends a 2-bit slave address, then DATA_WIDTH data bits LSB first, and aborts on a not-ready timeout.
// Ports: clk/reset (async, active-low); req_valid/req_ready/req_slave/req_data form the host request;
// done/error report completion; m1_address_valid/m1_address/m1_data/m1_valid drive the bus; m1_ready comes from the selected slave.
module serial_master_port #(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_slave,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  done,
    output logic                  error,
    output logic                  m1_address_valid,
    output logic                  m1_address,
    output logic                  m1_data,
    output logic                  m1_valid,
    input  logic                  m1_ready
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] ADDR_STROBE = 3'd1;
    localparam logic [2:0] ADDR_MSB    = 3'd2;
    localparam logic [2:0] ADDR_LSB    = 3'd3;
    localparam logic [2:0] GAP         = 3'd4;
    localparam logic [2:0] DATA        = 3'd5;
    localparam logic [2:0] FINISH      = 3'd6;
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    logic [2:0]            state_q, state_d;
    logic [1:0]            slave_q, slave_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bits_q, bits_d;
    logic                  error_q, error_d;
    logic                  req_ready_q, done_q, addr_valid_q, addr_q, data_q, valid_q;
    logic                  addr_d;

    always_comb begin
        state_d = state_q;
        slave_d = slave_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        bits_d  = bits_q;
        error_d = error_q;
        case (state_q)
            IDLE: if (req_valid) begin
                state_d = ADDR_STROBE;
                slave_d = req_slave;
                shift_d = req_data;
            end
            ADDR_STROBE: state_d = ADDR_MSB;
            ADDR_MSB:    state_d = ADDR_LSB;
            ADDR_LSB:    state_d = GAP;
            GAP: begin
                state_d = DATA;
                cnt_d   = '0;
                bits_d  = '0;
            end
            // A ready bit wins over the timeout that would otherwise fire on this cycle.
            DATA: if (m1_ready) begin
                cnt_d   = '0;
                shift_d = shift_q >> 1;
                bits_d  = bits_q + 1'b1;
                if (bits_q == BIT_LAST) begin
                    state_d = FINISH;
                    error_d = 1'b0;
                end
            end else if (cnt_q == TO_LAST) begin
                state_d = FINISH;
                error_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        addr_d = state_d == ADDR_MSB ? slave_d[1] : state_d == ADDR_LSB ? slave_d[0] : 1'b0;
    end

    // Outputs are registered from the next state so every bus signal lines up with its state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            slave_q      <= '0;
            shift_q      <= '0;
            cnt_q        <= '0;
            bits_q       <= '0;
            error_q      <= 1'b0;
            req_ready_q  <= 1'b1;
            done_q       <= 1'b0;
            addr_valid_q <= 1'b0;
            addr_q       <= 1'b0;
            data_q       <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            slave_q      <= slave_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            bits_q       <= bits_d;
            error_q      <= error_d;
            req_ready_q  <= state_d == IDLE;
            done_q       <= state_d == FINISH;
            addr_valid_q <= state_d == ADDR_STROBE;
            addr_q       <= addr_d;
            data_q       <= state_d == DATA ? shift_d[0] : 1'b0;
            valid_q      <= state_d == DATA;
        end
    end

    assign req_ready        = req_ready_q;
    assign done             = done_q;
    assign error            = error_q;
    assign m1_address_valid = addr_valid_q;
    assign m1_address       = addr_q;
    assign m1_data          = data_q;
    assign m1_valid         = valid_q;
endmodule

// File: tb/tb_serial_master_port.sv
// tb_serial_master_port: randomized scoreboard bench for serial_master_port against a cycle-pattern reference model.
module tb_serial_master_port;
    localparam int DW   = 8;
    localparam int TO   = 16;
    localparam int PMAX = 300;

    typedef struct {
        logic [1:0]    slave;
        logic [DW-1:0] bits;
        int            nbits;
        logic          err;
        int            lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          m1_ready = 1'b0;
    logic [1:0]    req_slave = '0;
    logic [DW-1:0] req_data = '0;
    logic          req_ready, done, error, m1_address_valid, m1_address, m1_data, m1_valid;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    bit   chain = 1'b0;
    bit   b2b = 1'b0;

    serial_master_port #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_slave(req_slave), .req_data(req_data), .done(done), .error(error),
        .m1_address_valid(m1_address_valid), .m1_address(m1_address),
        .m1_data(m1_data), .m1_valid(m1_valid), .m1_ready(m1_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_req_ready"}, int'(req_ready), 1);
        chk({tag, "_outputs"}, int'({done, error, m1_address_valid, m1_address, m1_data, m1_valid}), 0);
    endtask

    // Builds a per-cycle m1_ready pattern (cycle 1 = first cycle after acceptance, DATA from cycle 5),
    // predicts the outcome from the consume/timeout rules, then drives the request.
    task automatic run_xfer(input logic [1:0] sl, input logic [DW-1:0] d, input int mode, input int gap, input int stop_c);
        bit   pat [PMAX];
        int   k = 0;
        int   z = 0;
        int   c = 5;
        int   run;
        int   w;
        logic e = 1'b0;
        exp_t x;
        for (int i = 0; i < PMAX; i++) begin
            case (mode)
                0:       pat[i] = 1'b1;
                1:       pat[i] = ((i - 5) % 2) == 0;
                2:       pat[i] = 1'b0;
                3:       pat[i] = i >= 20;
                default: pat[i] = $urandom_range(0, 3) != 0;
            endcase
            if (i < 5) pat[i] = 1'($urandom);
        end
        if (mode == 5) begin
            while (c < PMAX) begin
                run = $urandom_range(0, 17);
                for (int j = 0; j < run && c < PMAX; j++) begin
                    pat[c] = 1'b0;
                    c++;
                end
                if (c < PMAX) begin
                    pat[c] = 1'b1;
                    c++;
                end
            end
            c = 5;
        end
        forever begin
            if (pat[c]) begin
                k++;
                z = 0;
                if (k == DW) break;
            end else begin
                z++;
                if (z == TO) begin
                    e = 1'b1;
                    break;
                end
            end
            c++;
        end
        x.slave = sl;
        x.bits  = '0;
        for (int i = 0; i < k; i++) x.bits[i] = d[i];
        x.nbits = k;
        x.err   = e;
        x.lat   = c + 1;
        if (stop_c == 0) exp_q.push_back(x);
        req_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        b2b = chain && gap == 0;
        req_valid = 1'b1;
        req_slave = sl;
        req_data  = d;
        for (w = 0; w < 400 && !req_ready; w++) begin
            @(posedge clk);
            #1;
        end
        if (!req_ready) begin
            chk("req_ready_wait", 0, 1);
            $fatal(1, "stuck waiting for req_ready");
        end
        @(posedge clk);
        #1;
        b2b = 1'b0;
        for (int c2 = 1; c2 < x.lat; c2++) begin
            m1_ready = pat[c2];
            if (c2 == stop_c) return;
            req_valid = 1'($urandom);
            req_slave = 2'($urandom);
            req_data  = DW'($urandom);
            @(posedge clk);
            #1;
        end
        m1_ready  = 1'($urandom);
        req_valid = 1'b0;
        chain     = 1'b1;
    endtask

    initial begin : monitor
        bit            busy = 1'b0;
        bit            strobe_ok = 1'b0;
        bit            proto_ok = 1'b1;
        int            acc = 0;
        int            rel = 0;
        int            obs_n = 0;
        int            last_done = -10;
        logic [1:0]    addr = '0;
        logic [DW-1:0] obs = '0;
        logic          last_err = 1'b0;
        logic          prev_v = 1'b0;
        logic          prev_r = 1'b0;
        logic          prev_d = 1'b0;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                busy     = 1'b0;
                last_err = 1'b0;
                prev_v   = 1'b0;
            end else begin
                if (busy) begin
                    rel = cyc - acc + 1;
                    if (rel == 1) strobe_ok = m1_address_valid;
                    else if (m1_address_valid) proto_ok = 1'b0;
                    if (rel == 2) addr[1] = m1_address;
                    else if (rel == 3) addr[0] = m1_address;
                    else if (m1_address) proto_ok = 1'b0;
                    if (rel <= 4 && (m1_valid || m1_data)) proto_ok = 1'b0;
                    if (!m1_valid && m1_data) proto_ok = 1'b0;
                    if (m1_valid && prev_v && !prev_r && m1_data != prev_d) proto_ok = 1'b0;
                    if (m1_valid && m1_ready) begin
                        if (obs_n < DW) obs[obs_n] = m1_data;
                        obs_n++;
                    end
                    if (done) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_done", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("strobe", int'(strobe_ok), 1);
                            chk("protocol", int'(proto_ok), 1);
                            chk("address", int'(addr), int'(e.slave));
                            chk("bit_count", obs_n, e.nbits);
                            chk("data_bits", int'(obs), int'(e.bits));
                            chk("error", int'(error), int'(e.err));
                            chk("latency", rel, e.lat);
                        end
                        busy      = 1'b0;
                        last_done = cyc;
                        last_err  = error;
                    end
                end else if (done) begin
                    chk("stray_done", 1, 0);
                end
                if (!done) chk("error_hold", int'(error), int'(last_err));
                if (req_valid && req_ready) begin
                    if (b2b) chk("b2b_accept_gap", cyc + 1 - last_done, 2);
                    busy      = 1'b1;
                    acc       = cyc + 1;
                    obs_n     = 0;
                    obs       = '0;
                    addr      = '0;
                    strobe_ok = 1'b0;
                    proto_ok  = 1'b1;
                end
                prev_v = m1_valid;
                prev_r = m1_ready;
                prev_d = m1_data;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        #1;
        reset = 1'b0;
        #1;
        chk_idle("por");
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_xfer(2'd1, 8'hA5, 0, 1, 0);
        run_xfer(2'd0, 8'h3C, 1, 0, 0);
        run_xfer(2'd3, DW'($urandom), 2, 0, 0);
        run_xfer(2'($urandom), DW'($urandom), 3, 0, 0);
        run_xfer(2'd2, DW'($urandom), 0, 1, 9);
        #1;
        reset     = 1'b0;
        req_valid = 1'b0;
        #1;
        chk_idle("abort");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        chain = 1'b0;
        run_xfer(2'd2, DW'($urandom), 0, 0, 0);
        run_xfer(2'd1, DW'($urandom), 4, 0, 0);
        run_xfer(2'd0, DW'($urandom), 4, 0, 0);
        repeat (40) run_xfer(2'($urandom), DW'($urandom), $urandom_range(0, 5), $urandom_range(0, 2), 0);
        req_valid = 1'b0;
        for (int w = 0; w < 400 && exp_q.size() != 0; w++) @(posedge clk);
        chk("scoreboard_drain", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_master_port.md
SERIAL_MASTER_PORT -- requirements
Module: serial_master_port

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, serial data bits per transfer (legal 1..32).
REQ-002 SHALL have parameter TIMEOUT, default 16, consecutive not-ready data cycles before abort (legal 1..255).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  host request strobe.
REQ-006 SHALL have port req_ready  output  1  port can accept a request.
REQ-007 SHALL have port req_slave  input  2  target slave id (0..2 legal, 3 unmapped).
REQ-008 SHALL have port req_data  input  DATA_WIDTH  word to send.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port error  output  1  status qualifying done, 1 = aborted by timeout.
REQ-011 SHALL have port m1_address_valid  output  1  start-of-address strobe to bus.
REQ-012 SHALL have port m1_address  output  1  serial address bit to bus.
REQ-013 SHALL have port m1_data  output  1  serial data bit to bus.
REQ-014 SHALL have port m1_valid  output  1  m1_data qualifier.
REQ-015 SHALL have port m1_ready  input  1  selected slave accepts current bit.

Function
REQ-016 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-017 States SHALL be IDLE, ADDR_STROBE, ADDR_MSB, ADDR_LSB, GAP, DATA, FINISH.
REQ-018 req_ready SHALL be 1 exactly when state is IDLE; request accepted on rising edge with req_valid=1 and req_ready=1.
REQ-019 On acceptance SHALL capture req_slave and req_data into internal registers and go to ADDR_STROBE; req_* SHALL be ignored in all other states.
REQ-020 ADDR_STROBE: m1_address_valid=1 for exactly one cycle, then ADDR_MSB.
REQ-021 ADDR_MSB: m1_address=captured slave[1] for one cycle, then ADDR_LSB.
REQ-022 ADDR_LSB: m1_address=captured slave[0] for one cycle, then GAP.
REQ-023 GAP: one cycle with all m1_* outputs 0 (bus routing decision cycle), then DATA.
REQ-024 DATA: m1_valid=1; m1_data=current bit; bits sent LSB first.
REQ-025 A bit SHALL be consumed only on a cycle with m1_valid=1 and m1_ready=1; the next bit appears the following cycle; otherwise m1_data holds.
REQ-026 After DATA_WIDTH consumed bits SHALL go to FINISH with error=0; m1_valid drops in the same edge.
REQ-027 Not-ready counter SHALL clear on each consumed bit and on DATA entry, increment on each DATA cycle with m1_ready=0, saturate-free width ceil(log2(TIMEOUT+1)).
REQ-028 When counter reaches TIMEOUT SHALL go to FINISH with error=1, regardless of bits already sent (covers unmapped slave 3).
REQ-029 m1_ready=1 on the cycle the counter would reach TIMEOUT SHALL take priority: bit consumed, no abort.
REQ-030 FINISH: done=1 for exactly one cycle, error valid in that cycle, then IDLE; error SHALL hold its value until next done.
REQ-031 m1_address SHALL be 0 outside ADDR_MSB/ADDR_LSB; m1_address_valid 0 outside ADDR_STROBE; m1_valid, m1_data 0 outside DATA.
REQ-032 m1_ready SHALL be ignored outside DATA.
REQ-033 Minimum transfer latency, acceptance edge to done=1, SHALL be 5+DATA_WIDTH cycles with m1_ready constantly 1.
REQ-034 Back-to-back: a request presented during FINISH SHALL be accepted on the first IDLE cycle, no earlier.

Reset
REQ-035 reset=0 SHALL immediately force state IDLE, req_ready=1, and done, error, m1_address_valid, m1_address, m1_data, m1_valid, counters and captured registers to 0.
REQ-036 Reset asserted mid-transfer SHALL abort without a done pulse; first acceptance possible on first rising edge after reset=1.

Verification
REQ-037 Slave 1, data 8'hA5, m1_ready=1 -> strobe cycle 1, address bits 0 then 1, gap, m1_data 1,0,1,0,0,1,0,1, done at cycle 13, error=0.
REQ-038 Slave 0, data 8'h3C, m1_ready toggling 1/0 every cycle -> each bit held through not-ready cycles, 8 bits in order, error=0.
REQ-039 Slave 3, m1_ready=0 always, TIMEOUT=16 -> 16 DATA cycles then done with error=1, then req_ready=1.
REQ-040 m1_ready=0 for 15 cycles then 1 on cycle 16 -> bit consumed, no abort, transfer completes error=0.
REQ-041 reset=0 asserted during DATA bit 4 -> all outputs 0 and req_ready=1 asynchronously, no done; new request after release completes normally.
REQ-042 req_valid held high across two transfers -> second accepted exactly one cycle after done, req_data changes during first transfer have no effect.
